// File: rtl/cr_pkg.sv
// Shared types and sizes for the commit/retire stage.
// ROB entry layout plus physical/architectural index widths.
package cr_pkg;
  localparam int DEPTH    = 16;
  localparam int TAG_W    = 4;
  localparam int PHYS_W   = 6;
  localparam int ARCH_W   = 5;
  localparam int NUM_ARCH = 32;

  typedef logic [TAG_W:0] ptr_t;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              regwrite;
    logic [ARCH_W-1:0] arch;
    logic [PHYS_W-1:0] phy;
    logic [31:0]       pc;
  } rob_entry_t;
endpackage

// File: rtl/commit_retire_rrat.sv
// Retirement RAT: committed arch->phys map, identity after reset.
// Ports: rd_arch/rd_phy read port; wr_en/wr_arch/wr_phy write port.
module commit_retire_rrat
  import cr_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ARCH_W-1:0] rd_arch,
  output logic [PHYS_W-1:0] rd_phy,
  input  logic              wr_en,
  input  logic [ARCH_W-1:0] wr_arch,
  input  logic [PHYS_W-1:0] wr_phy
);

  logic [PHYS_W-1:0] map_q [NUM_ARCH];
  logic [PHYS_W-1:0] map_d [NUM_ARCH];

  always_comb begin
    map_d = map_q;
    if (wr_en) map_d[wr_arch] = wr_phy;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_ARCH; i++)
        map_q[i] <= PHYS_W'(i);
    end else begin
      map_q <= map_d;
    end
  end

  assign rd_phy = map_q[rd_arch];

endmodule

// File: rtl/commit_retire.sv
// In-order commit/retire: circular ROB, RRAT, free-list return.
// Ports: alloc_* from rename, complete_* from WB, free-list/retire outs.
module commit_retire
  import cr_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              alloc_valid,
  input  logic              alloc_regwrite,
  input  logic [ARCH_W-1:0] alloc_arch_dest,
  input  logic [PHYS_W-1:0] alloc_phy_dest,
  input  logic [31:0]       alloc_pc,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              complete_valid,
  input  logic [TAG_W-1:0]  complete_tag,
  input  logic              freelist_ready,
  output logic              FreeList_WB,
  output logic [PHYS_W-1:0] reg_FreeList_WB,
  output logic              retire_valid,
  output logic [31:0]       retire_pc,
  output logic              rob_empty
);

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;

  rob_entry_t rob_q [DEPTH];
  rob_entry_t rob_d [DEPTH];

  logic              fl_q, fl_d;
  logic [PHYS_W-1:0] rfl_q, rfl_d;
  logic              rv_q, rv_d;
  logic [31:0]       rpc_q, rpc_d;

  logic [TAG_W-1:0]  head_idx;
  logic [TAG_W-1:0]  tail_idx;
  ptr_t              count;
  logic              full;
  logic              empty;
  logic              alloc_fire;
  logic              retire;
  logic              cmp_ok;
  rob_entry_t        head_e;
  logic [PHYS_W-1:0] rrat_phy;

  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];
  assign count    = tail_q - head_q;

  // Same index, opposite lap: the ring is full.
  assign full  = (head_idx == tail_idx) &&
                 (head_q[TAG_W] != tail_q[TAG_W]);
  assign empty = (head_q == tail_q);

  assign alloc_ready = !full;
  assign alloc_tag   = tail_idx;
  assign rob_empty   = (count == '0);

  assign alloc_fire = alloc_valid && !full;
  assign head_e     = rob_q[head_idx];

  // done is read from registered state, so a completion
  // retires no earlier than the following edge.
  assign retire = !empty && head_e.valid &&
                  head_e.done && freelist_ready;

  assign cmp_ok = complete_valid &&
                  rob_q[complete_tag].valid &&
                  !(alloc_fire && complete_tag == tail_idx);

  commit_retire_rrat u_rrat (
    .CLK     (CLK),
    .RESET   (RESET),
    .rd_arch (head_e.arch),
    .rd_phy  (rrat_phy),
    .wr_en   (retire && head_e.regwrite),
    .wr_arch (head_e.arch),
    .wr_phy  (head_e.phy)
  );

  always_comb begin
    rob_d  = rob_q;
    head_d = head_q;
    tail_d = tail_q;
    fl_d   = 1'b0;
    rv_d   = 1'b0;
    rfl_d  = rfl_q;
    rpc_d  = rpc_q;

    if (cmp_ok) rob_d[complete_tag].done = 1'b1;

    if (retire) begin
      rob_d[head_idx].valid = 1'b0;
      head_d = head_q + 1'b1;
      rv_d   = 1'b1;
      rpc_d  = head_e.pc;
      if (head_e.regwrite) begin
        fl_d  = 1'b1;
        rfl_d = rrat_phy;
      end
    end

    // Applied last so a new entry overrides any stale update.
    if (alloc_fire) begin
      rob_d[tail_idx] = '{
        valid:    1'b1,
        done:     1'b0,
        regwrite: alloc_regwrite,
        arch:     alloc_arch_dest,
        phy:      alloc_phy_dest,
        pc:       alloc_pc
      };
      tail_d = tail_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head_q <= '0;
      tail_q <= '0;
      fl_q   <= 1'b0;
      rfl_q  <= '0;
      rv_q   <= 1'b0;
      rpc_q  <= '0;
      for (int i = 0; i < DEPTH; i++)
        rob_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      fl_q   <= fl_d;
      rfl_q  <= rfl_d;
      rv_q   <= rv_d;
      rpc_q  <= rpc_d;
      rob_q  <= rob_d;
    end
  end

  assign FreeList_WB     = fl_q;
  assign reg_FreeList_WB = rfl_q;
  assign retire_valid    = rv_q;
  assign retire_pc       = rpc_q;

endmodule

// File: tb/tb_commit_retire.sv
// Self-checking bench for commit_retire.
// Directed table, corner sequences, random run against a queue model.
module tb_commit_retire;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        alloc_valid;
  logic        alloc_regwrite;
  logic [4:0]  alloc_arch_dest;
  logic [5:0]  alloc_phy_dest;
  logic [31:0] alloc_pc;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        complete_valid;
  logic [3:0]  complete_tag;
  logic        freelist_ready;
  logic        FreeList_WB;
  logic [5:0]  reg_FreeList_WB;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic        rob_empty;

  always #5 CLK = ~CLK;

  commit_retire dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .alloc_valid     (alloc_valid),
    .alloc_regwrite  (alloc_regwrite),
    .alloc_arch_dest (alloc_arch_dest),
    .alloc_phy_dest  (alloc_phy_dest),
    .alloc_pc        (alloc_pc),
    .alloc_ready     (alloc_ready),
    .alloc_tag       (alloc_tag),
    .complete_valid  (complete_valid),
    .complete_tag    (complete_tag),
    .freelist_ready  (freelist_ready),
    .FreeList_WB     (FreeList_WB),
    .reg_FreeList_WB (reg_FreeList_WB),
    .retire_valid    (retire_valid),
    .retire_pc       (retire_pc),
    .rob_empty       (rob_empty)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: program-order queue of in-flight instrs.
  typedef struct {
    int tag;
    bit rw;
    int arch;
    int phy;
    int pc;
    bit done;
  } m_ent_t;

  m_ent_t mq[$];
  int     m_next;
  int     m_rrat [32];
  bit     m_fl;
  bit     m_rv;
  int     m_rfl;
  int     m_rpc;

  task automatic m_reset();
    mq.delete();
    m_next = 0;
    for (int i = 0; i < 32; i++) m_rrat[i] = i;
    m_fl  = 0;
    m_rv  = 0;
    m_rfl = 0;
    m_rpc = 0;
  endtask

  task automatic m_step();
    bit     ret;
    bit     acc;
    m_ent_t h;
    ret = mq.size() > 0 && mq[0].done && freelist_ready;
    acc = alloc_valid && mq.size() < 16;
    if (complete_valid)
      foreach (mq[j])
        if (mq[j].tag == int'(complete_tag)) mq[j].done = 1;
    if (ret) begin
      h = mq.pop_front();
      m_rv  = 1;
      m_rpc = h.pc;
      if (h.rw) begin
        m_rfl = m_rrat[h.arch];
        m_fl  = 1;
        m_rrat[h.arch] = h.phy;
      end else begin
        m_fl = 0;
      end
    end else begin
      m_fl = 0;
      m_rv = 0;
    end
    if (acc) begin
      mq.push_back('{tag: m_next % 16, rw: alloc_regwrite,
                     arch: int'(alloc_arch_dest),
                     phy: int'(alloc_phy_dest),
                     pc: int'(alloc_pc), done: 0});
      m_next++;
    end
  endtask

  task automatic clr_in();
    alloc_valid     = 0;
    alloc_regwrite  = 0;
    alloc_arch_dest = 0;
    alloc_phy_dest  = 0;
    alloc_pc        = 0;
    complete_valid  = 0;
    complete_tag    = 0;
    freelist_ready  = 1;
  endtask

  task automatic mcycle();
    chk("rdy", alloc_ready, 32'(mq.size() < 16));
    chk("tag", alloc_tag, 32'(m_next % 16));
    chk("empty", rob_empty, 32'(mq.size() == 0));
    @(posedge CLK);
    m_step();
    #1;
    chk("fl", FreeList_WB, 32'(m_fl));
    chk("rfl", reg_FreeList_WB, m_rfl);
    chk("rv", retire_valid, 32'(m_rv));
    chk("rpc", retire_pc, m_rpc);
  endtask

  task automatic chk_reset_vals();
    chk("rst_empty", rob_empty, 1);
    chk("rst_rdy", alloc_ready, 1);
    chk("rst_tag", alloc_tag, 0);
    chk("rst_fl", FreeList_WB, 0);
    chk("rst_rfl", reg_FreeList_WB, 0);
    chk("rst_rv", retire_valid, 0);
    chk("rst_rpc", retire_pc, 0);
  endtask

  task automatic do_reset();
    RESET = 0;
    clr_in();
    m_reset();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk_reset_vals();
    RESET = 1;
  endtask

  task automatic alloc_in(input bit rw, input int a,
                          input int p, input int pc);
    alloc_valid     = 1;
    alloc_regwrite  = rw;
    alloc_arch_dest = 5'(a);
    alloc_phy_dest  = 6'(p);
    alloc_pc        = pc;
  endtask

  typedef struct {
    bit av, rw;
    int arch, phy, pc;
    bit cv;
    int ctag;
    bit fr;
    bit e_rdy;
    int e_tag;
    bit e_empty;
    bit e_fl;
    int e_rfl;
    bit e_rv;
    int e_rpc;
  } vec_t;

  vec_t vt [20];

  initial begin
    vt[0]  = '{1,1,3,40,'h100, 0,0,1, 1,0,1, 0,0,0,0};
    vt[1]  = '{0,0,0,0,0,      1,0,1, 1,1,0, 0,0,0,0};
    vt[2]  = '{0,0,0,0,0,      0,0,1, 1,1,0, 1,3,1,'h100};
    vt[3]  = '{1,1,5,33,'h104, 0,0,1, 1,1,1, 0,3,0,'h100};
    vt[4]  = '{1,1,5,34,'h108, 0,0,1, 1,2,0, 0,3,0,'h100};
    vt[5]  = '{0,0,0,0,0,      1,2,1, 1,3,0, 0,3,0,'h100};
    vt[6]  = '{0,0,0,0,0,      1,1,1, 1,3,0, 0,3,0,'h100};
    vt[7]  = '{0,0,0,0,0,      0,0,1, 1,3,0, 1,5,1,'h104};
    vt[8]  = '{0,0,0,0,0,      0,0,1, 1,3,0, 1,33,1,'h108};
    vt[9]  = '{1,1,3,50,'h10c, 0,0,1, 1,3,1, 0,33,0,'h108};
    vt[10] = '{1,1,5,51,'h110, 1,4,1, 1,4,0, 0,33,0,'h108};
    vt[11] = '{0,0,0,0,0,      1,3,1, 1,5,0, 0,33,0,'h108};
    vt[12] = '{0,0,0,0,0,      0,0,1, 1,5,0, 1,40,1,'h10c};
    vt[13] = '{0,0,0,0,0,      0,0,1, 1,5,0, 0,40,0,'h10c};
    vt[14] = '{0,0,0,0,0,      1,4,1, 1,5,0, 0,40,0,'h10c};
    vt[15] = '{0,0,0,0,0,      0,0,1, 1,5,0, 1,34,1,'h110};
    vt[16] = '{1,0,7,9,'h114,  0,0,1, 1,5,1, 0,34,0,'h110};
    vt[17] = '{0,0,0,0,0,      1,5,1, 1,6,0, 0,34,0,'h110};
    vt[18] = '{0,0,0,0,0,      0,0,1, 1,6,0, 0,34,1,'h114};
    vt[19] = '{0,0,0,0,0,      1,9,1, 1,6,1, 0,34,0,'h114};

    // Reset, then idle.
    do_reset();
    for (int i = 0; i < 10; i++) mcycle();

    // Directed table.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      alloc_valid     = vt[i].av;
      alloc_regwrite  = vt[i].rw;
      alloc_arch_dest = 5'(vt[i].arch);
      alloc_phy_dest  = 6'(vt[i].phy);
      alloc_pc        = vt[i].pc;
      complete_valid  = vt[i].cv;
      complete_tag    = 4'(vt[i].ctag);
      freelist_ready  = vt[i].fr;
      chk($sformatf("v%0d_rdy", i), alloc_ready, 32'(vt[i].e_rdy));
      chk($sformatf("v%0d_tag", i), alloc_tag, vt[i].e_tag);
      chk($sformatf("v%0d_empty", i), rob_empty, 32'(vt[i].e_empty));
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_fl", i), FreeList_WB, 32'(vt[i].e_fl));
      chk($sformatf("v%0d_rfl", i), reg_FreeList_WB, vt[i].e_rfl);
      chk($sformatf("v%0d_rv", i), retire_valid, 32'(vt[i].e_rv));
      chk($sformatf("v%0d_rpc", i), retire_pc, vt[i].e_rpc);
    end

    // Fill, full-blocking, wrap, simultaneous alloc+retire.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc_in(1, i + 1, 40 + i, 'h200 + 4 * i);
      mcycle();
    end
    chk("full_rdy", alloc_ready, 0);
    chk("full_tag", alloc_tag, 0);
    alloc_in(1, 20, 60, 'h300);
    mcycle();
    complete_valid = 1;
    complete_tag   = 0;
    mcycle();
    complete_valid = 0;
    chk("full_blk", alloc_ready, 0);
    mcycle();
    chk("wrap_rdy", alloc_ready, 1);
    chk("wrap_tag0", alloc_tag, 0);
    mcycle();
    chk("refull", alloc_ready, 0);
    alloc_valid    = 0;
    complete_valid = 1;
    complete_tag   = 1;
    mcycle();
    complete_tag   = 2;
    mcycle();
    complete_valid = 0;
    alloc_in(1, 21, 61, 'h304);
    mcycle();
    chk("sim_tag", alloc_tag, 2);
    chk("sim_rdy", alloc_ready, 1);
    clr_in();
    mcycle();

    // Free-list back-pressure.
    do_reset();
    alloc_in(1, 1, 20, 'h400);
    mcycle();
    clr_in();
    complete_valid = 1;
    complete_tag   = 0;
    mcycle();
    complete_valid = 0;
    freelist_ready = 0;
    for (int i = 0; i < 3; i++) begin
      mcycle();
      chk("stall_fl", FreeList_WB, 0);
    end
    freelist_ready = 1;
    mcycle();
    chk("unstall_fl", FreeList_WB, 1);
    chk("unstall_rfl", reg_FreeList_WB, 1);

    // Reset while entries are in flight.
    do_reset();
    alloc_in(1, 3, 45, 'h500);
    mcycle();
    clr_in();
    complete_valid = 1;
    complete_tag   = 0;
    mcycle();
    complete_valid = 0;
    for (int i = 0; i < 5; i++) begin
      alloc_in(1, 3 + i, 50 + i, 'h504 + 4 * i);
      complete_valid = (i < 2);
      complete_tag   = 4'(i + 1);
      mcycle();
    end
    chk("pre_rst_rv", retire_valid, 32'(m_rv));
    RESET = 0;
    clr_in();
    m_reset();
    #1;
    chk_reset_vals();
    @(posedge CLK);
    #1;
    RESET = 1;
    alloc_in(1, 3, 50, 'h600);
    mcycle();
    clr_in();
    complete_valid = 1;
    complete_tag   = 0;
    mcycle();
    complete_valid = 0;
    mcycle();
    chk("rrat_id", reg_FreeList_WB, 3);

    // Random run against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      alloc_valid     = ($urandom_range(0, 9) < 7);
      alloc_regwrite  = ($urandom_range(0, 3) != 0);
      alloc_arch_dest = 5'($urandom_range(0, 31));
      alloc_phy_dest  = 6'($urandom_range(0, 63));
      alloc_pc        = $urandom;
      complete_valid  = ($urandom_range(0, 9) < 6);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        complete_tag =
          4'(mq[$urandom_range(0, mq.size() - 1)].tag);
      else
        complete_tag = 4'($urandom_range(0, 15));
      freelist_ready  = ($urandom_range(0, 9) < 8);
      mcycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
